morse_encoder_seq: RTL and testbench
====================================

Name: morse_encoder_seq

Overview:
- Parametrised successor to the 8-letter Morse generator.
- Accepts one character index at a time over a valid/ready handshake and emits its full International Morse pattern on a single keyed output O.
- Covers A–Z, digits 0–9 and a word space, with standard unit timing (dot 1, dash 3, element gap 1, letter gap 3, word gap 7) scaled by a cycles-per-unit parameter.
- Sits between the character source and the key/LED driver.

Parameters:
- UNIT_CYCLES, 1, number of Clk cycles per Morse time unit; must be >= 1.
- CHAR_W, 6, width of the character index input; must be >= 6.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Clr  input  1  synchronous reset, active-low.
- I  input  CHAR_W  character index: 0–25 = A–Z, 26–35 = digits 0–9, 36 = word space.
- In_Valid  input  1  I is valid this cycle.
- In_Ready  output  1  block can accept a character this cycle.
- O  output  1  keyed Morse output, 1 = tone/mark.
- Busy  output  1  a character or gap is being emitted.
- Err  output  1  one-cycle pulse: an index > 36 was offered and dropped.

Behaviour:
- Reset: sampled on a Clk edge while Clr = 0.
  - State returns to IDLE; all counters clear.
  - O = 0, Busy = 0, Err = 0, In_Ready = 0 while Clr = 0.
  - Reset overrides any in-progress element, including mid-operation; the partial character is abandoned.
- Internal ROM: 37 entries, each a 3-bit length (1..5) plus a 5-bit pattern, MSB = first element, 1 = dash, 0 = dot.
  - Entry 36 is the word space (no marks).
  - The ROM is combinational on I.
- States: IDLE, MARK, EGAP, LGAP, WGAP.
  - Unit counter: counts 0..UNIT_CYCLES-1.
  - Unit-length counter: 3 bits, counts up to 7 units.
- IDLE:
  - In_Ready = 1.
  - Transfer occurs when In_Valid = 1 and In_Ready = 1 on a rising edge.
  - Index 0–35: load the pattern shift register and element count; go to MARK with duration 3 units if the first element is a dash, else 1 unit.
  - Index 36: go to WGAP, 7 units.
  - Index > 36: stay in IDLE; Err = 1 for exactly the next cycle; nothing emitted.
- MARK:
  - O = 1 for (1 or 3) × UNIT_CYCLES cycles.
  - On expiry, decrement the element count and shift the pattern.
  - If elements remain, go to EGAP (1 unit); otherwise go to LGAP (3 units).
- EGAP: O = 0; on expiry go to MARK with the next element's duration.
- LGAP: O = 0 for 3 units, then go to IDLE.
- WGAP: O = 0 for 7 units, then go to IDLE.
- Outputs:
  - O = 1 exactly when state = MARK; it is decoded from the registered state only, so it is glitch-free.
  - Busy = 1 whenever state != IDLE.
  - In_Ready = 1 only when state = IDLE and Clr = 1.
- Handshake:
  - In_Valid while Busy is ignored; the source must hold I and In_Valid until In_Ready.
  - I is sampled only on the transfer edge; changes to I during emission have no effect.
- Back-to-back characters: In_Valid held high gives a transfer on the first IDLE cycle.
  - Each character therefore costs its emission time plus 1 IDLE cycle.
- Latency: O rises on the cycle immediately following the transfer edge.
- Character duration in units: sum of element units + (n−1) element gaps + 3 letter-gap units.

Test Plan:
- UNIT_CYCLES=1, Clr low 2 cycles, then I=0 ('A' .-) with In_Valid at cycle 0 -> O=1 at cycle 1; O=0 at cycle 2; O=1 at cycles 3–5; O=0 at cycles 6–8; In_Ready=1 at cycle 9; Busy=1 for cycles 1–8.
- UNIT_CYCLES=4, I=4 ('E') -> O=1 for 4 cycles, then O=0 for 12 cycles with Busy=1, then In_Ready=1.
- UNIT_CYCLES=1, I=26 (digit 0, -----) -> 5 marks of 3 cycles each separated by 1-cycle gaps, then 3-cycle letter gap; Busy high for 22 cycles.
- I=40 with In_Valid -> Err=1 for exactly one cycle; O stays 0, Busy stays 0, In_Ready stays 1. Then I=36 -> O=0 and Busy=1 for 7×UNIT_CYCLES cycles.
- Send 'S' (index 18) with In_Valid held high; change I to 12 mid-emission -> 'S' (...) pattern emitted unchanged, then 'M' (--) transferred on the first IDLE cycle.
- Clr driven low during the dash of 'T' (index 19) -> at the next edge O=0, Busy=0, In_Ready=0. After Clr returns high, In_Ready=1 and a new 'T' emits a full 3-unit dash.

Source files
------------

// File: rtl/morse_encoder_seq.sv
// Purpose : accepts one character index (A-Z, 0-9, word space) and keys its Morse pattern on O.
// Latency : O rises the cycle after the transfer edge; each character costs its emission time plus 1 idle cycle.
// Backpr. : In_Ready is high only in IDLE; the source holds I/In_Valid until accepted, so nothing is ever dropped except bad indices.
module morse_encoder_seq #(
  parameter int UNIT_CYCLES = 1,
  parameter int CHAR_W      = 6
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [CHAR_W-1:0] I,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic              O,
  output logic              Busy,
  output logic              Err
);

  // Unit counter width; a single-cycle unit still needs a 1-bit counter that stays at 0.
  localparam int                UW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0]     UNIT_LAST  = UW'(UNIT_CYCLES - 1);
  localparam logic [CHAR_W-1:0] LAST_CHAR  = CHAR_W'(35);
  localparam logic [CHAR_W-1:0] WORD_SPACE = CHAR_W'(36);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MARK = 3'd1,
    EGAP = 3'd2,
    LGAP = 3'd3,
    WGAP = 3'd4
  } state_t;

  state_t          state;
  logic [UW-1:0]   ucnt;   // cycles within the current unit
  logic [2:0]      lcnt;   // units elapsed in the current mark/gap
  logic [2:0]      dur;    // length of the current mark/gap in units
  logic [4:0]      pat;    // remaining elements, next element in bit 4 (1 = dash)
  logic [2:0]      nel;    // elements still to be sent, including the current one

  logic [5:0]      idx;
  logic [7:0]      rom_ent;
  logic [2:0]      rom_len;
  logic [4:0]      rom_pat;
  logic            unit_end;
  logic            phase_end;

  assign idx     = I[5:0];
  assign rom_len = rom_ent[7:5];
  assign rom_pat = rom_ent[4:0];

  // Character ROM: {length, left-aligned pattern}; entries 36 and above carry no marks.
  always_comb begin
    rom_ent = 8'h00;
    case (idx)
      6'd0:  rom_ent = {3'd2, 5'b01000}; // A .-
      6'd1:  rom_ent = {3'd4, 5'b10000}; // B -...
      6'd2:  rom_ent = {3'd4, 5'b10100}; // C -.-.
      6'd3:  rom_ent = {3'd3, 5'b10000}; // D -..
      6'd4:  rom_ent = {3'd1, 5'b00000}; // E .
      6'd5:  rom_ent = {3'd4, 5'b00100}; // F ..-.
      6'd6:  rom_ent = {3'd3, 5'b11000}; // G --.
      6'd7:  rom_ent = {3'd4, 5'b00000}; // H ....
      6'd8:  rom_ent = {3'd2, 5'b00000}; // I ..
      6'd9:  rom_ent = {3'd4, 5'b01110}; // J .---
      6'd10: rom_ent = {3'd3, 5'b10100}; // K -.-
      6'd11: rom_ent = {3'd4, 5'b01000}; // L .-..
      6'd12: rom_ent = {3'd2, 5'b11000}; // M --
      6'd13: rom_ent = {3'd2, 5'b10000}; // N -.
      6'd14: rom_ent = {3'd3, 5'b11100}; // O ---
      6'd15: rom_ent = {3'd4, 5'b01100}; // P .--.
      6'd16: rom_ent = {3'd4, 5'b11010}; // Q --.-
      6'd17: rom_ent = {3'd3, 5'b01000}; // R .-.
      6'd18: rom_ent = {3'd3, 5'b00000}; // S ...
      6'd19: rom_ent = {3'd1, 5'b10000}; // T -
      6'd20: rom_ent = {3'd3, 5'b00100}; // U ..-
      6'd21: rom_ent = {3'd4, 5'b00010}; // V ...-
      6'd22: rom_ent = {3'd3, 5'b01100}; // W .--
      6'd23: rom_ent = {3'd4, 5'b10010}; // X -..-
      6'd24: rom_ent = {3'd4, 5'b10110}; // Y -.--
      6'd25: rom_ent = {3'd4, 5'b11000}; // Z --..
      6'd26: rom_ent = {3'd5, 5'b11111}; // 0 -----
      6'd27: rom_ent = {3'd5, 5'b01111}; // 1 .----
      6'd28: rom_ent = {3'd5, 5'b00111}; // 2 ..---
      6'd29: rom_ent = {3'd5, 5'b00011}; // 3 ...--
      6'd30: rom_ent = {3'd5, 5'b00001}; // 4 ....-
      6'd31: rom_ent = {3'd5, 5'b00000}; // 5 .....
      6'd32: rom_ent = {3'd5, 5'b10000}; // 6 -....
      6'd33: rom_ent = {3'd5, 5'b11000}; // 7 --...
      6'd34: rom_ent = {3'd5, 5'b11100}; // 8 ---..
      6'd35: rom_ent = {3'd5, 5'b11110}; // 9 ----.
      default: rom_ent = 8'h00;          // word space and out-of-range
    endcase
  end

  assign unit_end  = (ucnt == UNIT_LAST);
  assign phase_end = unit_end && (lcnt == (dur - 3'd1));

  // Sequencer: accepts a character in IDLE, then walks marks and gaps unit by unit.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state <= IDLE;
      ucnt  <= '0;
      lcnt  <= '0;
      dur   <= '0;
      pat   <= '0;
      nel   <= '0;
      Err   <= 1'b0;
    end else begin
      Err <= 1'b0;
      if (state == IDLE) begin
        ucnt <= '0;
        lcnt <= '0;
        if (In_Valid) begin
          if (I <= LAST_CHAR) begin
            pat   <= rom_pat;
            nel   <= rom_len;
            dur   <= rom_pat[4] ? 3'd3 : 3'd1;
            state <= MARK;
          end else if (I == WORD_SPACE) begin
            dur   <= 3'd7;
            state <= WGAP;
          end else begin
            // Unknown index: consumed and flagged, nothing keyed.
            Err <= 1'b1;
          end
        end
      end else if (phase_end) begin
        ucnt <= '0;
        lcnt <= '0;
        case (state)
          MARK: begin
            nel <= nel - 3'd1;
            pat <= {pat[3:0], 1'b0};
            if (nel > 3'd1) begin
              dur   <= 3'd1;
              state <= EGAP;
            end else begin
              dur   <= 3'd3;
              state <= LGAP;
            end
          end
          EGAP: begin
            // pat was already shifted when the previous mark ended.
            dur   <= pat[4] ? 3'd3 : 3'd1;
            state <= MARK;
          end
          default: state <= IDLE; // LGAP / WGAP complete
        endcase
      end else if (unit_end) begin
        ucnt <= '0;
        lcnt <= lcnt + 3'd1;
      end else begin
        ucnt <= ucnt + UW'(1);
      end
    end
  end

  // Outputs decode straight from the registered state, so O never glitches.
  assign O        = (state == MARK);
  assign Busy     = (state != IDLE);
  assign In_Ready = (state == IDLE) && Clr;

endmodule

// File: tb/tb_morse_encoder_seq.sv
// Purpose : directed stimulus on two instances (1 and 4 cycles per unit) with a per-cycle expectation queue.
// Latency : the stimulus pushes the expected {O,Busy,In_Ready,Err} for every cycle it drives.
// Backpr. : the monitor pops one entry per falling edge while entries are pending.
module tb_morse_encoder_seq;

  logic       Clk;
  logic       clr0, vld0, clr1, vld1;
  logic [5:0] i0, i1;
  logic       rdy0, o0, busy0, err0;
  logic       rdy1, o1, busy1, err1;

  typedef struct {
    bit         d;
    logic [3:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  morse_encoder_seq #(.UNIT_CYCLES(1), .CHAR_W(6)) u1 (
    .Clk(Clk), .Clr(clr0), .I(i0), .In_Valid(vld0),
    .In_Ready(rdy0), .O(o0), .Busy(busy0), .Err(err0)
  );

  morse_encoder_seq #(.UNIT_CYCLES(4), .CHAR_W(6)) u4 (
    .Clk(Clk), .Clr(clr1), .I(i1), .In_Valid(vld1),
    .In_Ready(rdy1), .O(o1), .Busy(busy1), .Err(err1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: compares one pending expectation per cycle, mid-cycle.
  always @(negedge Clk) begin
    exp_t       e;
    logic [3:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = e.d ? {o1, busy1, rdy1, err1} : {o0, busy0, rdy0, err0};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got {O,Busy,Rdy,Err}=%b want %b at t=%0t", e.nm, act, e.v, $time);
      end
    end
  end

  // One cycle of stimulus on instance d, plus the outputs expected during that cycle.
  task automatic cyc(input int d, input logic clr, input logic vld, input logic [5:0] idx,
                     input logic [3:0] ev, input string nm);
    exp_t e;
    @(posedge Clk);
    #1;
    if (d == 0) begin
      clr0 = clr; vld0 = vld; i0 = idx;
    end else begin
      clr1 = clr; vld1 = vld; i1 = idx;
    end
    e.d  = (d != 0);
    e.v  = ev;
    e.nm = nm;
    q.push_back(e);
  endtask

  // Emission cycles: u is the hand-written per-unit O trace ('1' mark, '0' gap), Busy high throughout.
  task automatic emit(input int d, input string u, input logic vld, input logic [5:0] idx,
                      input string nm);
    int uc;
    uc = (d == 0) ? 1 : 4;
    for (int k = 0; k < u.len(); k++)
      for (int r = 0; r < uc; r++)
        cyc(d, 1'b1, vld, idx, {(u.getc(k) == "1"), 1'b1, 1'b0, 1'b0}, nm);
  endtask

  // Full character: transfer cycle, emission, then the idle cycle with In_Ready back up.
  task automatic send(input int d, input logic [5:0] idx, input string u, input string nm);
    cyc(d, 1'b1, 1'b1, idx, 4'b0010, {nm, "_xfer"});
    emit(d, u, 1'b0, idx, nm);
    cyc(d, 1'b1, 1'b0, 6'd0, 4'b0010, {nm, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    clr0 = 1'b0; vld0 = 1'b0; i0 = 6'd0;
    clr1 = 1'b0; vld1 = 1'b0; i1 = 6'd0;

    // Reset: everything low, including In_Ready.
    cyc(0, 1'b0, 1'b0, 6'd0, 4'b0000, "reset0");
    cyc(0, 1'b0, 1'b1, 6'd0, 4'b0000, "reset1");

    // 'A' .- : 1 mark, 1 gap, 3 mark, 3 letter gap.
    send(0, 6'd0, "10111000", "A");

    // Digit 0 ----- : 22 busy cycles.
    send(0, 6'd26, "1110111011101110111000", "D0");

    // Bad index: one-cycle Err, otherwise idle.
    cyc(0, 1'b1, 1'b1, 6'd40, 4'b0010, "bad_xfer");
    cyc(0, 1'b1, 1'b0, 6'd0,  4'b0011, "err_pulse");
    cyc(0, 1'b1, 1'b0, 6'd0,  4'b0010, "err_clear");

    // Word space: 7 silent busy units.
    send(0, 6'd36, "0000000", "WS1");

    // 'S' with In_Valid held and I changed to 'M' mid-emission; 'M' taken on the first idle cycle.
    cyc(0, 1'b1, 1'b1, 6'd18, 4'b0010, "S_xfer");
    emit(0, "1010", 1'b1, 6'd18, "S_a");
    emit(0, "1000", 1'b1, 6'd12, "S_b");
    cyc(0, 1'b1, 1'b1, 6'd12, 4'b0010, "M_xfer");
    emit(0, "1110111000", 1'b0, 6'd12, "M");
    cyc(0, 1'b1, 1'b0, 6'd0, 4'b0010, "M_idle");

    // Reset during the dash of 'T'.
    cyc(0, 1'b1, 1'b1, 6'd19, 4'b0010, "T_xfer");
    emit(0, "1", 1'b0, 6'd0, "T_dash");
    cyc(0, 1'b0, 1'b0, 6'd0, 4'b1100, "T_clr_edge");
    cyc(0, 1'b0, 1'b0, 6'd0, 4'b0000, "T_clr_hold");
    send(0, 6'd19, "111000", "T_again");

    // UNIT_CYCLES=4 instance.
    cyc(1, 1'b1, 1'b0, 6'd0, 4'b0010, "u4_idle");
    send(1, 6'd4, "1000", "E4");
    send(1, 6'd36, "0000000", "WS4");

    // Reset mid-unit on the 4-cycle instance, then 'E' must still be exactly 4 mark cycles.
    cyc(1, 1'b1, 1'b1, 6'd19, 4'b0010, "T4_xfer");
    for (int k = 0; k < 6; k++) cyc(1, 1'b1, 1'b0, 6'd0, 4'b1100, "T4_dash");
    cyc(1, 1'b0, 1'b0, 6'd0, 4'b1100, "T4_clr_edge");
    cyc(1, 1'b0, 1'b0, 6'd0, 4'b0000, "T4_clr_hold");
    cyc(1, 1'b1, 1'b0, 6'd0, 4'b0010, "T4_rel");
    send(1, 6'd4, "1000", "E4_again");

    // Drain the queue with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge Clk);
    @(posedge Clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
